issue_scoreboard: RTL and testbench

Register-hazard gate between the per-warp instruction buffer and the issue/dispatch stage. Tracks per warp which destination registers have an instruction in flight, stalls the buffer's head instruction while any register it reads or writes is pending, and marks its destination register busy when it issues. Entries clear on the writeback's end-of-packet beat.

---
 rtl/issue_scoreboard_if.sv | 32 +++
 rtl/issue_scoreboard.sv | 86 ++++++++
 tb/tb_issue_scoreboard.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scoreboard_if.sv
// Handshake bundle between the instruction buffer, the issue scoreboard and
// dispatch, plus the writeback release channel.
interface issue_scoreboard_if #(
   parameter int NW_BITS  = 2,
   parameter int NR_BITS  = 6,
   parameter int NUM_REGS = 64
) ();
   logic                ibuf_valid;
   logic [NW_BITS-1:0]  ibuf_wid;
   logic                ibuf_wb;
   logic [NR_BITS-1:0]  ibuf_rd;
   logic [NUM_REGS-1:0] ibuf_used_regs;
   logic                ibuf_ready;
   logic                issue_valid;
   logic                issue_ready;
   logic                wb_valid;
   logic [NW_BITS-1:0]  wb_wid;
   logic [NR_BITS-1:0]  wb_rd;
   logic                wb_eop;

   modport master (
      output ibuf_valid, ibuf_wid, ibuf_wb, ibuf_rd, ibuf_used_regs,
      output issue_ready, wb_valid, wb_wid, wb_rd, wb_eop,
      input  ibuf_ready, issue_valid
   );

   modport slave (
      input  ibuf_valid, ibuf_wid, ibuf_wb, ibuf_rd, ibuf_used_regs,
      input  issue_ready, wb_valid, wb_wid, wb_rd, wb_eop,
      output ibuf_ready, issue_valid
   );
endinterface

// File: rtl/issue_scoreboard.sv
// Per-warp register hazard gate between the instruction buffer and dispatch.
// Optional stall watchdog is built only when SCOREBOARD_WATCHDOG_EN is defined.
module issue_scoreboard #(
   parameter int NUM_WARPS = 4,
   parameter int NW_BITS   = 2,
   parameter int NUM_REGS  = 64,
   parameter int NR_BITS   = 6,
   parameter int TIMEOUT   = 10000
) (
   input  logic            clk,
   input  logic            reset,
   issue_scoreboard_if.slave sb,
   output logic            stall_timeout
);

   logic [NUM_REGS-1:0] inuse [NUM_WARPS];
   logic                conflict;
   logic                fire;

   if (NW_BITS != $clog2(NUM_WARPS) || (1 << NR_BITS) < NUM_REGS || TIMEOUT < 1) begin : g_bad_params
      $error("issue_scoreboard: inconsistent parameters");
   end

   assign conflict       = |(sb.ibuf_used_regs & inuse[sb.ibuf_wid]);
   assign sb.issue_valid = sb.ibuf_valid && !conflict && !reset;
   assign sb.ibuf_ready  = sb.issue_ready && !conflict && !reset;
   assign fire           = sb.ibuf_valid && sb.ibuf_ready;

   // Release is written before set so a same-warp, same-register collision
   // leaves the bit busy; x0 is never tracked.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            inuse[w] <= '0;
         end
      end else begin
         if (sb.wb_valid && sb.wb_eop) begin
            inuse[sb.wb_wid][sb.wb_rd] <= 1'b0;
         end
         if (fire && sb.ibuf_wb && (sb.ibuf_rd != '0)) begin
            inuse[sb.ibuf_wid][sb.ibuf_rd] <= 1'b1;
         end
      end
   end

`ifdef SCOREBOARD_WATCHDOG_EN
   logic [31:0] stall_count;
   logic        timeout_flag;
   logic        count_hit;

   assign count_hit = (stall_count == 32'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count  <= '0;
         timeout_flag <= 1'b0;
      end else begin
         if (sb.ibuf_valid && conflict) begin
            if (stall_count != '1) begin
               stall_count <= stall_count + 32'd1;
            end
         end else begin
            stall_count <= '0;
         end
         if (count_hit) begin
            timeout_flag <= 1'b1;
         end
      end
   end

   // Visible as soon as the count reaches the threshold, then held by the flag.
   assign stall_timeout = !reset && (timeout_flag || count_hit);

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset && !timeout_flag && count_hit) begin
         $error("issue_scoreboard: stall timeout wid=%0d inuse=%h",
                sb.ibuf_wid, inuse[sb.ibuf_wid]);
      end
   end
`endif
`else
   assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed self-checking bench for issue_scoreboard: hazard stall, release,
// cross-warp isolation, x0 handling, set/release collisions and watchdog.
module tb_issue_scoreboard;

   logic clk;
   logic reset;
   logic stall_timeout;
   int   n_checks;
   int   n_fail;

`ifdef SCOREBOARD_WATCHDOG_EN
   localparam logic WD_EXP = 1'b1;
`else
   localparam logic WD_EXP = 1'b0;
`endif

   issue_scoreboard_if #(.NW_BITS(2), .NR_BITS(6), .NUM_REGS(64)) sb ();

   issue_scoreboard #(
      .NUM_WARPS(4), .NW_BITS(2), .NUM_REGS(64), .NR_BITS(6), .TIMEOUT(16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .sb            (sb),
      .stall_timeout (stall_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] bit_of(input int r);
      bit_of = 64'd1 << r;
   endfunction

   task automatic drive_head(input logic v, input logic [1:0] w, input logic wb,
                             input logic [5:0] rd, input logic [63:0] used);
      sb.ibuf_valid     = v;
      sb.ibuf_wid       = w;
      sb.ibuf_wb        = wb;
      sb.ibuf_rd        = rd;
      sb.ibuf_used_regs = used;
   endtask

   task automatic drive_wb(input logic v, input logic [1:0] w,
                           input logic [5:0] rd, input logic eop);
      sb.wb_valid = v;
      sb.wb_wid   = w;
      sb.wb_rd    = rd;
      sb.wb_eop   = eop;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sb.issue_ready = 1'b1;
      drive_head(1'b1, 2'd0, 1'b0, 6'd0, '1);
      drive_wb(1'b0, 2'd0, 6'd0, 1'b0);
      step();
      step();
      n_checks++;
      if (sb.issue_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_issue_valid: got %b expected 0", sb.issue_valid);
      end
      n_checks++;
      if (sb.ibuf_ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_ibuf_ready: got %b expected 0", sb.ibuf_ready);
      end
      n_checks++;
      if (stall_timeout !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_stall_timeout: got %b expected 0", stall_timeout);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL post_reset_clear: got %b expected 1", sb.issue_valid);
      end
   endtask

   task automatic test_issue_and_set();
      drive_head(1'b1, 2'd0, 1'b1, 6'd5, bit_of(5));
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b1 || sb.ibuf_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL issue_same_cycle: got valid=%b ready=%b expected 1/1",
                  sb.issue_valid, sb.ibuf_ready);
      end
      step();
      drive_head(1'b1, 2'd0, 1'b0, 6'd0, bit_of(5));
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b0 || sb.ibuf_ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL set_visible_next: got valid=%b ready=%b expected 0/0",
                  sb.issue_valid, sb.ibuf_ready);
      end
   endtask

   task automatic test_cross_warp();
      drive_head(1'b1, 2'd1, 1'b0, 6'd0, bit_of(5));
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL cross_warp: got %b expected 1", sb.issue_valid);
      end
      drive_head(1'b1, 2'd0, 1'b0, 6'd0, bit_of(5));
      #1;
   endtask

   task automatic test_release();
      drive_wb(1'b1, 2'd0, 6'd5, 1'b1);
      #1;
      n_checks++;
      if (sb.ibuf_ready !== 1'b0 || sb.issue_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL no_bypass: got valid=%b ready=%b expected 0/0",
                  sb.issue_valid, sb.ibuf_ready);
      end
      step();
      drive_wb(1'b0, 2'd0, 6'd0, 1'b0);
      #1;
      n_checks++;
      if (sb.ibuf_ready !== 1'b1 || sb.issue_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL release_issue: got valid=%b ready=%b expected 1/1",
                  sb.issue_valid, sb.ibuf_ready);
      end
      step();
   endtask

   task automatic test_x0();
      drive_head(1'b1, 2'd0, 1'b1, 6'd0, bit_of(0));
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL x0_writer: got %b expected 1", sb.issue_valid);
      end
      step();
      drive_head(1'b1, 2'd0, 1'b0, 6'd0, bit_of(0));
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL x0_reader: got %b expected 1", sb.issue_valid);
      end
      step();
   endtask

   task automatic test_eop_and_dual_update();
      drive_head(1'b1, 2'd0, 1'b1, 6'd7, bit_of(7));
      step();
      drive_head(1'b1, 2'd0, 1'b0, 6'd0, bit_of(7));
      drive_wb(1'b1, 2'd0, 6'd7, 1'b0);
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rd7_pending: got %b expected 0", sb.issue_valid);
      end
      step();
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL non_eop_keeps: got %b expected 0", sb.issue_valid);
      end
      drive_head(1'b1, 2'd0, 1'b1, 6'd9, bit_of(9));
      drive_wb(1'b1, 2'd0, 6'd7, 1'b1);
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL rd9_issue: got %b expected 1", sb.issue_valid);
      end
      step();
      drive_wb(1'b0, 2'd0, 6'd0, 1'b0);
      drive_head(1'b1, 2'd0, 1'b0, 6'd0, bit_of(7));
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL rd7_cleared: got %b expected 1", sb.issue_valid);
      end
      drive_head(1'b1, 2'd0, 1'b0, 6'd0, bit_of(9));
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rd9_set: got %b expected 0", sb.issue_valid);
      end
   endtask

   task automatic test_same_reg_collision();
      drive_head(1'b1, 2'd2, 1'b1, 6'd12, bit_of(12));
      step();
      drive_head(1'b1, 2'd2, 1'b1, 6'd12, 64'd0);
      drive_wb(1'b1, 2'd2, 6'd12, 1'b1);
      step();
      drive_wb(1'b0, 2'd0, 6'd0, 1'b0);
      drive_head(1'b1, 2'd2, 1'b0, 6'd0, bit_of(12));
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL collision_set_wins: got %b expected 0", sb.issue_valid);
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive_wb(1'b1, 2'd2, 6'd12, 1'b1);
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset_discards: got %b expected 1", sb.issue_valid);
      end
      drive_head(1'b0, 2'd0, 1'b0, 6'd0, 64'd0);
      step();
      drive_wb(1'b0, 2'd0, 6'd0, 1'b0);
   endtask

   task automatic test_issue_ready_low();
      sb.issue_ready = 1'b0;
      drive_head(1'b1, 2'd1, 1'b1, 6'd20, bit_of(20));
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b1 || sb.ibuf_ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL ready_low: got valid=%b ready=%b expected 1/0",
                  sb.issue_valid, sb.ibuf_ready);
      end
      step();
      sb.issue_ready = 1'b1;
      drive_head(1'b1, 2'd1, 1'b0, 6'd0, bit_of(20));
      #1;
      n_checks++;
      if (sb.issue_valid !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL ready_low_no_set: got %b expected 1", sb.issue_valid);
      end
      step();
   endtask

   task automatic test_watchdog();
      drive_head(1'b1, 2'd3, 1'b1, 6'd30, bit_of(30));
      step();
      drive_head(1'b1, 2'd3, 1'b0, 6'd0, bit_of(30));
      repeat (15) step();
      n_checks++;
      if (stall_timeout !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL wd_early: got %b expected 0", stall_timeout);
      end
      step();
      n_checks++;
      if (stall_timeout !== WD_EXP) begin
         n_fail++;
         $display("[TB] FAIL wd_fire: got %b expected %b", stall_timeout, WD_EXP);
      end
      repeat (4) step();
      drive_head(1'b0, 2'd0, 1'b0, 6'd0, 64'd0);
      step();
      step();
      n_checks++;
      if (stall_timeout !== WD_EXP) begin
         n_fail++;
         $display("[TB] FAIL wd_sticky: got %b expected %b", stall_timeout, WD_EXP);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_issue_and_set();
      test_cross_warp();
      test_release();
      test_x0();
      test_eop_and_dual_update();
      test_same_reg_collision();
      test_reset_mid();
      test_issue_ready_low();
      test_watchdog();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
